// File: rtl/keypad_pkg.sv
// keypad_pkg: FSM state encoding and the key-code to matrix-position map
// shared by the keypad emulator and the keypad scanner decode.
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_BOUNCE_IN  = 3'd1,
        ST_HOLD       = 3'd2,
        ST_BOUNCE_OUT = 3'd3,
        ST_GAP        = 3'd4
    } state_t;

    localparam int KEY_COUNT = 16;

    // Entry [code] = {col_idx[1:0], row_idx[1:0]}, listed from code F down to 0.
    localparam logic [KEY_COUNT-1:0][3:0] KEY_POS_TABLE = {
        4'hB,   // F -> (2,3)
        4'h3,   // E -> (0,3)
        4'hF,   // D -> (3,3)
        4'hE,   // C -> (3,2)
        4'hD,   // B -> (3,1)
        4'hC,   // A -> (3,0)
        4'hA,   // 9 -> (2,2)
        4'h6,   // 8 -> (1,2)
        4'h2,   // 7 -> (0,2)
        4'h9,   // 6 -> (2,1)
        4'h5,   // 5 -> (1,1)
        4'h1,   // 4 -> (0,1)
        4'h8,   // 3 -> (2,0)
        4'h4,   // 2 -> (1,0)
        4'h0,   // 1 -> (0,0)
        4'h7    // 0 -> (1,3)
    };

    // Returns {col_idx, row_idx} for a key code.
    function automatic logic [3:0] key_pos(input logic [3:0] code);
        return KEY_POS_TABLE[code];
    endfunction

endpackage

// File: rtl/keypad_key_map.sv
// keypad_key_map: combinational key code -> matrix column/row index.
module keypad_key_map
    import keypad_pkg::*;
(
    input  logic [3:0] key_code,
    output logic [1:0] col_idx,
    output logic [1:0] row_idx
);

    assign {col_idx, row_idx} = key_pos(key_code);

endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: device end of a 4x4 matrix keypad. Accepts key codes over
// valid/ready, then closes the matching contact so that the scanner's
// active-low column drive is reflected on the active-low row lines.
// Optional contact bounce is built when KEYPAD_EMU_BOUNCE_EN is defined.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES    = 8_000_000,
    parameter int GAP_CYCLES     = 4_000_000,
    parameter int BOUNCE_CYCLES  = 100_000,
    parameter int BOUNCE_TOGGLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic       busy,
    output logic       done
);

    localparam int MAX_HG   = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_BB   = (BOUNCE_CYCLES > BOUNCE_TOGGLES) ? BOUNCE_CYCLES : BOUNCE_TOGGLES;
    localparam int MAX_PARAM = (MAX_HG > MAX_BB) ? MAX_HG : MAX_BB;
    localparam int CNT_W    = $clog2(MAX_PARAM) + 1;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int TOG_W = $clog2(BOUNCE_TOGGLES) + 1;
    localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
    localparam logic [TOG_W-1:0] TOG_LOAD    = TOG_W'(BOUNCE_TOGGLES - 1);
    logic [TOG_W-1:0] tog_q;
`endif

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             contact_q;
    logic [3:0]       code_q;
    logic             key_ready_q;
    logic             busy_q;
    logic             done_q;
    logic [3:0]       row_q;
    logic [3:0]       row_d;
    logic [1:0]       col_idx;
    logic [1:0]       row_idx;
    logic             col_hit;

    keypad_key_map u_key_map (
        .key_code (code_q),
        .col_idx  (col_idx),
        .row_idx  (row_idx)
    );

    // Key sequencing: one down-counter, reloaded on every state entry, times each phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            contact_q   <= 1'b0;
            code_q      <= '0;
            key_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
            tog_q       <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    key_ready_q <= 1'b1;
                    if (key_valid && key_ready_q) begin
                        code_q      <= key_code;
                        key_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        contact_q   <= 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
                        state_q     <= ST_BOUNCE_IN;
                        cnt_q       <= BOUNCE_LOAD;
                        tog_q       <= TOG_LOAD;
`else
                        state_q     <= ST_HOLD;
                        cnt_q       <= HOLD_LOAD;
`endif
                    end
                end
`ifdef KEYPAD_EMU_BOUNCE_EN
                ST_BOUNCE_IN: begin
                    if (cnt_q == '0) begin
                        if (tog_q == '0) begin
                            // Final toggle lands the contact closed for the hold.
                            state_q   <= ST_HOLD;
                            cnt_q     <= HOLD_LOAD;
                            contact_q <= 1'b1;
                        end else begin
                            contact_q <= ~contact_q;
                            cnt_q     <= BOUNCE_LOAD;
                            tog_q     <= tog_q - 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_BOUNCE_OUT: begin
                    if (cnt_q == '0) begin
                        if (tog_q == '0) begin
                            // Final toggle lands the contact open for the gap.
                            state_q   <= ST_GAP;
                            cnt_q     <= GAP_LOAD;
                            contact_q <= 1'b0;
                        end else begin
                            contact_q <= ~contact_q;
                            cnt_q     <= BOUNCE_LOAD;
                            tog_q     <= tog_q - 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`endif
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        contact_q <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
                        state_q   <= ST_BOUNCE_OUT;
                        cnt_q     <= BOUNCE_LOAD;
                        tog_q     <= TOG_LOAD;
`else
                        state_q   <= ST_GAP;
                        cnt_q     <= GAP_LOAD;
`endif
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        // Ready rises with done so a new key can follow back-to-back.
                        state_q     <= ST_IDLE;
                        cnt_q       <= '0;
                        done_q      <= 1'b1;
                        key_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= '0;
                    contact_q   <= 1'b0;
                    key_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // A closed contact bridges column col_idx to row row_idx; any other row stays high.
    assign col_hit = contact_q && !col[col_idx];

    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        assign row_d[gi] = !(col_hit && (row_idx == 2'(gi)));
    end

    // Registered row response, updated every clock regardless of FSM state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q <= 4'hF;
        end else begin
            row_q <= row_d;
        end
    end

    assign key_ready = key_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign row       = row_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed and randomized key sequences checked cycle by
// cycle against a timeline model of the emulated contact.
`timescale 1ns/1ps
module tb_keypad_emulator;

    localparam int HOLD = 20;
    localparam int GAP  = 10;
    localparam int BC   = 2;
    localparam int BT   = 4;
`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int BOUNCE_LEN = BC * BT;
`else
    localparam int BOUNCE_LEN = 0;
`endif
    localparam int TOTAL = 2 * BOUNCE_LEN + HOLD + GAP;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [3:0] col = 4'hF;
    logic       key_ready;
    logic [3:0] row;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    keypad_emulator #(
        .HOLD_CYCLES    (HOLD),
        .GAP_CYCLES     (GAP),
        .BOUNCE_CYCLES  (BC),
        .BOUNCE_TOGGLES (BT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .col       (col),
        .row       (row),
        .busy      (busy),
        .done      (done)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: t counts clock edges since the accept edge.
    bit         m_active = 1'b0;
    bit         m_ready  = 1'b0;
    bit         m_done   = 1'b0;
    int         m_t      = 0;
    logic [3:0] m_code   = 4'h0;
    logic [3:0] m_row    = 4'hF;
    int         pos_col [16];
    int         pos_row [16];

    // Contact state during the cycle following edge t of a sequence.
    function automatic bit closed(input int t);
        if (t < BOUNCE_LEN)            return ((t / BC) % 2) == 0;
        if (t < BOUNCE_LEN + HOLD)     return 1'b1;
        if (t < 2 * BOUNCE_LEN + HOLD) return ((t - BOUNCE_LEN - HOLD) / BC) % 2 == 1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict, advance, then compare every output.
    task automatic tick();
        bit         cc;
        bit         acc;
        logic [3:0] er;
        logic [3:0] kc;
        cc  = m_active && closed(m_t);
        er  = 4'hF;
        if (cc && !col[pos_col[m_code]]) er[pos_row[m_code]] = 1'b0;
        acc = rst_n && key_valid && m_ready;
        kc  = key_code;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_active = 1'b0;
            m_ready  = 1'b0;
            m_done   = 1'b0;
            m_row    = 4'hF;
        end else begin
            m_row  = er;
            m_done = 1'b0;
            if (acc) begin
                m_active = 1'b1;
                m_t      = 0;
                m_code   = kc;
                $display("key %h accepted at %0t", kc, $time);
            end else if (m_active) begin
                m_t++;
                if (m_t == TOTAL) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end
            m_ready = !m_active;
        end
        check("row", 32'(row), 32'(m_row));
        check("busy", 32'(busy), 32'(m_active));
        check("done", 32'(done), 32'(m_done));
        check("key_ready", 32'(key_ready), 32'(m_ready));
    endtask

    task automatic send_key(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic run_to_done(input string tag, input bit rnd_col);
        for (int i = 0; i < TOTAL + 5; i++) begin
            if (rnd_col) col = 4'($urandom);
            tick();
            if (done === 1'b1) break;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        int cols [4][4];
        int low_cnt;
        int done_at;
        int edges;
        logic prev_r0;

        // Key layout by column, rows 0..3 top to bottom.
        cols[0] = '{4'h1, 4'h4, 4'h7, 4'hE};
        cols[1] = '{4'h2, 4'h5, 4'h8, 4'h0};
        cols[2] = '{4'h3, 4'h6, 4'h9, 4'hF};
        cols[3] = '{4'hA, 4'hB, 4'hC, 4'hD};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                pos_col[cols[c][r]] = c;
                pos_row[cols[c][r]] = r;
            end
        end

        // Reset for 3 cycles, then release.
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("ready_after_reset", 32'(key_ready), 32'd1);

        // Key 5 with matching column: row 1 low for the closed time.
        col = 4'b1101;
        send_key(4'h5);
        low_cnt = 0;
        done_at = -1;
        for (int i = 1; i <= TOTAL + 3; i++) begin
            tick();
            if (row !== 4'hF) low_cnt++;
            if (done === 1'b1 && done_at < 0) done_at = i;
        end
        check("k5_low_cycles", 32'(low_cnt), 32'(HOLD + BOUNCE_LEN));
        check("k5_done_latency", 32'(done_at), 32'(TOTAL));

        // Key 5 with a non-matching column: row never moves.
        col = 4'b1110;
        send_key(4'h5);
        low_cnt = 0;
        for (int i = 1; i <= TOTAL + 2; i++) begin
            tick();
            if (row !== 4'hF) low_cnt++;
        end
        check("k5_nomatch_low", 32'(low_cnt), 32'd0);

        // Key 0 with scanner idle columns, then key E in the done cycle.
        col = 4'h0;
        send_key(4'h0);
        run_to_done("k0_done", 1'b0);
        send_key(4'hE);
        check("kE_back_to_back", 32'(busy), 32'd1);
        run_to_done("kE_done", 1'b0);

        // key_valid held while busy with a changing code.
        col = 4'($urandom);
        send_key(4'h3);
        key_valid = 1'b1;
        for (int i = 0; i < TOTAL - 1; i++) begin
            key_code = 4'($urandom);
            col      = 4'($urandom);
            tick();
        end
        key_valid = 1'b0;
        run_to_done("k3_done", 1'b1);

        // Reset pulse mid-hold on key D, then a fresh key D.
        col = 4'h0;
        send_key(4'hD);
        repeat (BOUNCE_LEN + 10) tick();
        rst_n = 1'b0;
        tick();
        check("rst_mid_row", 32'(row), 32'hF);
        rst_n = 1'b1;
        repeat (TOTAL + 2) tick();
        send_key(4'hD);
        run_to_done("kD_after_reset", 1'b0);

        // Random keys with random column patterns, sometimes back-to-back.
        for (int n = 0; n < 6; n++) begin
            send_key(4'($urandom_range(15)));
            run_to_done("rand_done", 1'b1);
            if ($urandom_range(1) == 1) repeat ($urandom_range(3)) tick();
        end

`ifdef KEYPAD_EMU_BOUNCE_EN
        // Bounce burst on key 1: count row[0] transitions over the sequence.
        col = 4'b1110;
        send_key(4'h1);
        edges   = 0;
        prev_r0 = row[0];
        for (int i = 0; i < TOTAL + 2; i++) begin
            tick();
            if (row[0] !== prev_r0) edges++;
            prev_r0 = row[0];
        end
        check("bounce_edges", 32'(edges), 32'(2 * (BT + 1)));
`else
        edges   = 0;
        prev_r0 = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Behavioural 4x4 matrix-keypad emulator: the device end of the keypad row/column interface. It accepts key codes over a valid/ready handshake, then presses and releases the requested key by answering the scanner's column drive on the row lines. Its key-code-to-position mapping is the inverse of the team's keypad scanner. It lets boards and benches run the scanner without a physical keypad.

## Interface
- HOLD_CYCLES, 8_000_000: clocks the contact stays stably closed per key; must be ≥1.
- GAP_CYCLES, 4_000_000: clocks the contact stays open after release before the next key is accepted; must be ≥1.
- BOUNCE_CYCLES, 100_000: clocks per bounce half-period. Used only with bounce compiled in.
- BOUNCE_TOGGLES, 4: contact toggles per bounce burst; must be even. Used only with bounce compiled in.
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- key_valid  in  1  key request valid.
- key_code  in  4  key to press, 0x0–0xF.
- key_ready  out  1  emulator can accept a key.
- col  in  4  column drive from the scanner, active-low.
- row  out  4  row response to the scanner, active-low, idle 4'hF.
- busy  out  1  a key sequence is in progress.
- done  out  1  one-cycle pulse when a sequence completes.

## Operation
- Key map (code → column c, row r):
  - 1→(0,0), 4→(0,1), 7→(0,2), E→(0,3).
  - 2→(1,0), 5→(1,1), 8→(1,2), 0→(1,3).
  - 3→(2,0), 6→(2,1), 9→(2,2), F→(2,3).
  - A→(3,0), B→(3,1), C→(3,2), D→(3,3).
- Transfer: a key is accepted on a clock edge with key_valid && key_ready. key_code is latched at that edge; later changes to key_code are ignored. key_valid is ignored while key_ready=0.
- FSM states: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP.
  - IDLE: key_ready=1, contact open. Accept → BOUNCE_IN (or HOLD when bounce is compiled out).
  - BOUNCE_IN: contact closes on entry. Contact toggles every BOUNCE_CYCLES clocks, BOUNCE_TOGGLES times, and ends closed. Then → HOLD.
  - HOLD: contact closed for exactly HOLD_CYCLES clocks. Then → BOUNCE_OUT (or GAP when bounce is compiled out).
  - BOUNCE_OUT: contact opens on entry, toggles BOUNCE_TOGGLES times, and ends open. Then → GAP.
  - GAP: contact open for GAP_CYCLES clocks. Then → IDLE with done=1 for that one cycle.
- Row function, evaluated every clock: row[r] <= 0 iff the contact is closed and col[c]==0; otherwise row[r] <= 1. All other row bits are 1.
  - Several low column bits (for example the scanner's idle 4'h0) still pull row r low if bit c is among them.
- busy = 1 in every state except IDLE.
- A single down-counter serves all timed states. Width is $clog2 of the largest parameter plus 1. The counter reloads on every state entry.

## Timing
- Reset: state IDLE, row=4'hF, key_ready=0, busy=0, done=0, counter=0, contact open. key_ready rises on the first clock after rst_n goes high.
- Reset mid-sequence: at the reset edge the contact opens and the latched code is discarded. row=4'hF on the following edge. No done pulse.
- Accept edge → contact closed in the next cycle → row responds 1 clk after col matches (registered output).
- Timed states last exactly their parameter count in clk cycles.
- Minimum time from accept to done: HOLD_CYCLES + GAP_CYCLES (+2·BOUNCE_TOGGLES·BOUNCE_CYCLES with bounce).
- done and key_ready both rise in the same cycle. A new key may be accepted in that cycle, so back-to-back keys are allowed.
- A col change reaches row in 1 clk, whatever the state.

## Configuration
- KEYPAD_EMU_BOUNCE_EN defined: the BOUNCE_IN and BOUNCE_OUT states and their toggle counter are built.
- KEYPAD_EMU_BOUNCE_EN undefined: those states are absent. IDLE→HOLD and HOLD→GAP directly, and BOUNCE_* parameters are unused.

## Structure
- Package keypad_pkg holds:
  - the FSM state enum;
  - the key-map constants;
  - a function key_pos(code) that returns {col_idx, row_idx}.
- The package is shared with the scanner's decode so both ends use the same map.
- One sub-module, keypad_key_map: combinational, key_code[3:0] → col_idx[1:0], row_idx[1:0].

## Test plan
Bench parameters: HOLD=20, GAP=10, BOUNCE_CYCLES=2, BOUNCE_TOGGLES=4.

- Reset: hold rst_n low for 3 cycles, then release → row=4'hF, busy=0 throughout. key_ready=0 during reset and 1 one cycle after release.
- Key 5, col=4'b1101 → row=4'b1101 for exactly 20 cycles. With col=4'b1110 over the same interval, row stays 4'hF. done pulses once, 30 cycles after accept (bounce off).
- Key 0 with col=4'h0 (scanner idle) → row=4'b0111 during HOLD. Then key E sent in the done cycle → accepted immediately, and row=4'b0111 again with no idle cycle between sequences.
- key_valid held high while busy, with key_code changing each cycle → key_ready stays 0 and row tracks only the first key.
- rst_n pulsed low mid-HOLD on key D → row=4'hF on the next edge, no done, and a fresh key D completes normally afterwards.
- Bounce on, key 1, col=4'b1110 → row[0] toggles every 2 cycles, 4 times, then holds low for 20 cycles. It then toggles 4 times, ends high, and done pulses 10 cycles later.
